// File: rtl/flag_selector.sv
// rtl/flag_selector.sv - frame-aligned flag index selector driven by debounced buttons and auto-advance
`timescale 1ns/1ps
module flag_selector #(
    parameter int DEBOUNCE      = 2,
    parameter int REPEAT_FRAMES = 30,
    parameter int AUTO_FRAMES   = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    input  logic [6:0] max,
    output logic [6:0] selector,
    output logic       changed
);
    localparam int              RW        = $clog2(REPEAT_FRAMES + 2);
    localparam logic [3:0]      DB_MAX    = 4'(DEBOUNCE);
    localparam logic [RW-1:0]   RP_LAST   = RW'(REPEAT_FRAMES - 1);
    localparam logic [9:0]      AUTO_LAST = 10'(AUTO_FRAMES - 1);

    // bit 0 = next, bit 1 = prev, bit 2 = auto_en
    logic [2:0]          meta_q, meta_d, sync_q, sync_d;
    logic [1:0][3:0]     db_q, db_d;
    logic [1:0][RW-1:0]  rep_q, rep_d;
    logic [9:0]          auto_q, auto_d;
    logic [6:0]          sel_q, sel_d;
    logic                changed_q, changed_d;
    logic [1:0]          press;

    always_comb begin
        meta_d    = {auto_en, btn_prev, btn_next};
        sync_d    = meta_q;
        db_d      = db_q;
        rep_d     = rep_q;
        auto_d    = auto_q;
        sel_d     = sel_q;
        press     = 2'b00;
        changed_d = 1'b0;
        if (frame_tick) begin
            for (int i = 0; i < 2; i++) begin
                if (!sync_q[i]) begin
                    db_d[i]  = 4'd0;
                    rep_d[i] = '0;
                end else if (db_q[i] != DB_MAX) begin
                    db_d[i]  = db_q[i] + 4'd1;
                    press[i] = (db_q[i] == DB_MAX - 4'd1);
                end else if (REPEAT_FRAMES > 0) begin
                    if (rep_q[i] == RP_LAST) begin
                        rep_d[i] = '0;
                        press[i] = 1'b1;
                    end else begin
                        rep_d[i] = rep_q[i] + RW'(1);
                    end
                end
            end

            // Clamp outranks everything: events on this tick are dropped
            if (sel_q > max) begin
                sel_d  = 7'd0;
                auto_d = 10'd0;
            end else if (press != 2'b00) begin
                auto_d = 10'd0;
                case (press)
                    2'b11:   sel_d = 7'd0;
                    2'b01:   sel_d = (sel_q == max) ? 7'd0 : sel_q + 7'd1;
                    default: sel_d = (sel_q == 7'd0) ? max : sel_q - 7'd1;
                endcase
            end else if (!sync_q[2]) begin
                auto_d = 10'd0;
            end else if (auto_q == AUTO_LAST) begin
                auto_d = 10'd0;
                sel_d  = (sel_q == max) ? 7'd0 : sel_q + 7'd1;
            end else begin
                auto_d = auto_q + 10'd1;
            end
            changed_d = (sel_d != sel_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= 3'b000;
            sync_q    <= 3'b000;
            db_q      <= '0;
            rep_q     <= '0;
            auto_q    <= 10'd0;
            sel_q     <= 7'd0;
            changed_q <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            db_q      <= db_d;
            rep_q     <= rep_d;
            auto_q    <= auto_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign selector = sel_q;
    assign changed  = changed_q;
endmodule

// File: tb/tb_flag_selector.sv
// tb/tb_flag_selector.sv - directed plus randomized tick-level checks of flag_selector
`timescale 1ns/1ps
module tb_flag_selector;
    localparam int DB   = 2;
    localparam int REP  = 3;
    localparam int AUTO = 4;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       frame_tick = 0;
    logic       btn_next = 0;
    logic       btn_prev = 0;
    logic       auto_en = 0;
    logic [6:0] max_v = 7'd81;
    logic [6:0] selector;
    logic       changed;

    int checks = 0;
    int failures = 0;

    // Reference state: consecutive high ticks per button, ticks into the auto window
    int m_sel = 0, m_chg = 0, held_n = 0, held_p = 0, m_acnt = 0;

    flag_selector #(.DEBOUNCE(DB), .REPEAT_FRAMES(REP), .AUTO_FRAMES(AUTO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_next(btn_next), .btn_prev(btn_prev), .auto_en(auto_en),
        .max(max_v), .selector(selector), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit fires(input int held);
        return (held == DB) || (REP > 0 && held > DB && ((held - DB) % REP) == 0);
    endfunction

    task automatic model_step();
        int  old = m_sel;
        int  mx  = int'(max_v);
        bit  pn, pp;
        held_n = btn_next ? held_n + 1 : 0;
        held_p = btn_prev ? held_p + 1 : 0;
        pn = btn_next && fires(held_n);
        pp = btn_prev && fires(held_p);
        if (m_sel > mx) begin
            m_sel = 0; m_acnt = 0;
        end else if (pn && pp) begin
            m_sel = 0; m_acnt = 0;
        end else if (pn) begin
            m_sel = (m_sel == mx) ? 0 : m_sel + 1; m_acnt = 0;
        end else if (pp) begin
            m_sel = (m_sel == 0) ? mx : m_sel - 1; m_acnt = 0;
        end else if (!auto_en) begin
            m_acnt = 0;
        end else begin
            m_acnt++;
            if (m_acnt == AUTO) begin
                m_acnt = 0;
                m_sel = (m_sel == mx) ? 0 : m_sel + 1;
            end
        end
        m_chg = (m_sel != old) ? 1 : 0;
    endtask

    task automatic do_tick(input string tag);
        repeat (3) @(negedge clk);
        frame_tick = 1;
        model_step();
        @(negedge clk);
        frame_tick = 0;
        check({tag, "_sel"}, int'(selector), m_sel);
        check({tag, "_chg"}, int'(changed), m_chg);
        @(negedge clk);
        check({tag, "_idle_chg"}, int'(changed), 0);
        check({tag, "_idle_sel"}, int'(selector), m_sel);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int k = 0; k < n; k++) do_tick(tag);
    endtask

    task automatic set_btn(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_sel", int'(selector), 0);
        check("reset_chg", int'(changed), 0);
        rst_n = 1;

        set_btn(1, 0); ticks("short", 1);
        set_btn(0, 0); ticks("short_rel", 1);
        check("short_press_none", int'(selector), 0);

        set_btn(1, 0); ticks("debounce", 2);
        check("debounce_one", int'(selector), 1);
        ticks("repeat", 3);
        check("repeat_two", int'(selector), 2);

        set_btn(0, 0); ticks("rel", 1);
        set_btn(1, 1); ticks("home", 2);
        check("home_zero", int'(selector), 0);
        set_btn(0, 0); ticks("rel", 1);
        set_btn(1, 1); ticks("home_again", 2);
        set_btn(0, 0); ticks("rel", 1);
        set_btn(0, 1); ticks("prev_wrap", 2);
        check("prev_wrap_max", int'(selector), 81);
        set_btn(0, 0); ticks("rel", 1);
        set_btn(1, 0); ticks("next_wrap", 2);
        check("next_wrap_zero", int'(selector), 0);
        set_btn(0, 0); ticks("rel", 1);

        auto_en = 1; ticks("auto", 8);
        check("auto_two", int'(selector), 2);
        ticks("auto_w", 1);
        btn_next = 1; ticks("auto_manual", 2);
        btn_next = 0; ticks("auto_restart", 4);
        auto_en = 0; ticks("auto_off", 1);

        max_v = 7'd0;
        set_btn(1, 1); ticks("home0", 2);
        set_btn(0, 0); ticks("rel", 1);
        set_btn(1, 0); ticks("max0_next", 2);
        set_btn(0, 1); ticks("max0_prev", 4);
        set_btn(0, 0); ticks("rel", 1);

        max_v = 7'd50;
        set_btn(0, 1); ticks("to50", 2);
        check("at_fifty", int'(selector), 50);
        set_btn(0, 0); ticks("rel", 1);
        max_v = 7'd40; ticks("clamp", 1);
        check("clamp_zero", int'(selector), 0);
        max_v = 7'd81;

        set_btn(1, 0); ticks("pre_rst", 1);
        @(negedge clk);
        rst_n = 0;
        #1 check("rst_async_sel", int'(selector), 0);
        m_sel = 0; held_n = 0; held_p = 0; m_acnt = 0;
        @(negedge clk);
        rst_n = 1;
        ticks("post_rst", 1);
        check("post_rst_no_press", int'(selector), 0);
        ticks("post_rst2", 1);
        check("post_rst_press", int'(selector), 1);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) btn_next = 1'($urandom);
            if ($urandom_range(0, 3) == 0) btn_prev = 1'($urandom);
            if ($urandom_range(0, 7) == 0) auto_en = 1'($urandom);
            if ($urandom_range(0, 15) == 0) max_v = 7'($urandom_range(0, 90));
            else if ($urandom_range(0, 7) == 0) max_v = 7'd81;
            do_tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
